// File: rtl/ustc_dn_pkg.sv
// Purpose: shared routing-mode encodings for the downstream crossbar stream.
// Latency: n/a (types only).
// Backpressure: n/a.
package ustc_dn_pkg;

  typedef enum logic [1:0] {
    MODE_ROUTE = 2'd0,  // per-lane select with enable bit
    MODE_BCAST = 2'd1,  // every output lane takes input lane 0
    MODE_IDENT = 2'd2,  // lane j of every group takes input lane j
    MODE_ZERO  = 2'd3   // all lanes zero, beat still flows
  } dn_mode_e;

endpackage

// File: rtl/ustc_dn_lane_mux.sv
// Purpose: produce one routed output lane from the input lanes, its idx field and the mode.
// Latency: combinational.
// Backpressure: none; pure datapath.
// Ports: i_in (all input lanes), i_idx (this lane's {enable, select} field),
//        i_mode (routing mode), o_lane (routed lane). LANE_J is the lane's position in its group.
module ustc_dn_lane_mux
  import ustc_dn_pkg::*;
#(
  parameter int N_XBAR_IN = 8,
  parameter int DW_LINE   = 32,
  parameter int DW_IDX    = $clog2(N_XBAR_IN) + 1,
  parameter int LANE_J    = 0
) (
  input  logic [N_XBAR_IN*DW_LINE-1:0] i_in,
  input  logic [DW_IDX-1:0]            i_idx,
  input  logic [1:0]                   i_mode,
  output logic [DW_LINE-1:0]           o_lane
);

  localparam int SW = $clog2(N_XBAR_IN);

  logic          w_en;
  logic [SW-1:0] w_sel;

  // Top bit enables the lane; the low bits pick the source lane.
  assign w_en  = i_idx[DW_IDX-1];
  assign w_sel = i_idx[SW-1:0];

  always_comb begin
    o_lane = '0;
    case (dn_mode_e'(i_mode))
      MODE_ROUTE: if (w_en) o_lane = i_in[w_sel*DW_LINE +: DW_LINE];
      MODE_BCAST: o_lane = i_in[0 +: DW_LINE];
      MODE_IDENT: o_lane = i_in[LANE_J*DW_LINE +: DW_LINE];
      default:    o_lane = '0;
    endcase
  end

endmodule

// File: rtl/ustc_dn_stream.sv
// Purpose: buffer input beats in a small FIFO, route the head to NUM_XBAR groups of lanes, register the result.
// Latency: two edges from input accept to out_valid (FIFO write, then output register load); no bypass.
// Backpressure: in_ready = !full; the output register holds while out_valid && !out_ready.
// Ports: clk/reset (async active-low); in_valid/in_ready/in/idx/mode input beat;
//        out_valid/out_ready/out output beat; xfer_cnt counts output handshakes (wraps at 16 bits).
module ustc_dn_stream
  import ustc_dn_pkg::*;
#(
  parameter int NUM_XBAR     = 4,
  parameter int N_XBAR_IN    = 8,
  parameter int DW_DATA      = 32,
  parameter int NUM_PER_LINE = 1,
  parameter int DW_IDX       = $clog2(N_XBAR_IN) + 1,
  parameter int DEPTH        = 4,
  localparam int DW_LINE     = DW_DATA * NUM_PER_LINE,
  localparam int N_DN_IN     = NUM_XBAR * N_XBAR_IN
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_XBAR_IN*DW_LINE-1:0] in,
  input  logic [N_DN_IN*DW_IDX-1:0]    idx,
  input  logic [1:0]                   mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N_DN_IN*DW_LINE-1:0]   out,
  output logic [15:0]                  xfer_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // FIFO storage: not reset, only the pointers and occupancy qualify it.
  logic [N_XBAR_IN*DW_LINE-1:0] r_mem_in   [DEPTH];
  logic [N_DN_IN*DW_IDX-1:0]    r_mem_idx  [DEPTH];
  logic [1:0]                   r_mem_mode [DEPTH];

  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_cnt;

  logic [N_DN_IN*DW_LINE-1:0] r_out;
  logic                       r_out_vld;
  logic [15:0]                r_xfer_cnt;

  logic                         w_full, w_empty, w_push, w_pop;
  logic [N_XBAR_IN*DW_LINE-1:0] w_head_in;
  logic [N_DN_IN*DW_IDX-1:0]    w_head_idx;
  logic [1:0]                   w_head_mode;
  logic [N_DN_IN*DW_LINE-1:0]   w_routed;

  assign w_full   = (r_cnt == FULL_CNT);
  assign w_empty  = (r_cnt == '0);
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;
  // Load the output register whenever it is free or being drained this cycle.
  assign w_pop    = !w_empty && (!r_out_vld || out_ready);

  assign w_head_in   = r_mem_in[r_rptr];
  assign w_head_idx  = r_mem_idx[r_rptr];
  assign w_head_mode = r_mem_mode[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_in[r_wptr]   <= in;
      r_mem_idx[r_wptr]  <= idx;
      r_mem_mode[r_wptr] <= mode;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Routing of the FIFO head: one lane mux per output lane.
  for (genvar g = 0; g < NUM_XBAR; g++) begin : g_grp
    for (genvar j = 0; j < N_XBAR_IN; j++) begin : g_lane
      ustc_dn_lane_mux #(
        .N_XBAR_IN (N_XBAR_IN),
        .DW_LINE   (DW_LINE),
        .DW_IDX    (DW_IDX),
        .LANE_J    (j)
      ) u_lane_mux (
        .i_in   (w_head_in),
        .i_idx  (w_head_idx[(g*N_XBAR_IN+j)*DW_IDX +: DW_IDX]),
        .i_mode (w_head_mode),
        .o_lane (w_routed[(g*N_XBAR_IN+j)*DW_LINE +: DW_LINE])
      );
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out      <= '0;
      r_out_vld  <= 1'b0;
      r_xfer_cnt <= '0;
    end else begin
      if (w_pop) begin
        r_out     <= w_routed;
        r_out_vld <= 1'b1;
      end else if (out_ready) begin
        r_out_vld <= 1'b0;
      end
      if (r_out_vld && out_ready) r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end
  end

  assign out_valid = r_out_vld;
  assign out       = r_out;
  assign xfer_cnt  = r_xfer_cnt;

endmodule
